// File: rtl/nn_train_scheduler_if.sv
// Bundles the sample stream, the Neural_Network launch/done handshake and
// the scheduler status outputs. The master side is the environment (uart,
// network core, bench); the slave side is the scheduler itself.
interface nn_train_scheduler_if #(
  parameter int NPIXEL   = 784,
  parameter int AW       = 2,
  parameter int CNT_BITS = 14
);
  logic                sample_valid;
  logic [NPIXEL-1:0]   sample_pixel;
  logic [3:0]          sample_label;
  logic                hold;
  logic                nn_start;
  logic [NPIXEL-1:0]   nn_pixel;
  logic [3:0]          nn_label;
  logic                nn_done;
  logic                busy;
  logic [AW:0]         fifo_level;
  logic [CNT_BITS-1:0] done_count;
  logic [CNT_BITS-1:0] drop_count;
  logic                timeout_err;

  modport master (
    output sample_valid, sample_pixel, sample_label, hold, nn_done,
    input  nn_start, nn_pixel, nn_label, busy, fifo_level,
           done_count, drop_count, timeout_err
  );

  modport slave (
    input  sample_valid, sample_pixel, sample_label, hold, nn_done,
    output nn_start, nn_pixel, nn_label, busy, fifo_level,
           done_count, drop_count, timeout_err
  );
endinterface

// File: rtl/nn_train_scheduler.sv
// Training-pass scheduler between the uart receiver and the Neural_Network
// core. Incoming {label,pixel} samples are queued in a small FIFO; one pass
// is launched at a time with a single-cycle start pulse, the operands are
// held for the whole pass, and the pass ends on nn_done or a watchdog.
module nn_train_scheduler #(
  parameter int NPIXEL   = 784,
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int TIMEOUT  = 1048576,
  parameter int CNT_BITS = 14
) (
  input  logic clk,
  input  logic reset_b,
  nn_train_scheduler_if.slave bus
);

  localparam int               TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]      LVL_FULL = (AW + 1)'(DEPTH);
  localparam int               EW       = NPIXEL + 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t              r_state;
  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_level;
  logic [TW-1:0]       r_timer;
  logic                r_nn_start;
  logic [NPIXEL-1:0]   r_nn_pixel;
  logic [3:0]          r_nn_label;
  logic [CNT_BITS-1:0] r_done_count;
  logic [CNT_BITS-1:0] r_drop_count;
  logic                r_timeout_err;

  logic                w_full;
  logic                w_empty;
  logic                w_label_ok;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_timer_exp;
  logic [EW-1:0]       w_head;

  // Full/empty come from the registered level, so a pop in the same cycle
  // never makes room for a push that arrives while the FIFO is full.
  assign w_full      = (r_level == LVL_FULL);
  assign w_empty     = (r_level == '0);
  assign w_label_ok  = (bus.sample_label <= 4'd9);
  assign w_push      = bus.sample_valid && !w_full && w_label_ok;
  assign w_drop      = bus.sample_valid && !w_push;
  assign w_pop       = (r_state == S_IDLE) && !w_empty && !bus.hold;
  assign w_timer_exp = (r_timer == TMR_LAST);
  assign w_head      = r_mem[r_rptr];

  // Sample storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.sample_label, bus.sample_pixel};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2**AW.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Pass sequencer: launch on pop, one start cycle, then wait for done or watchdog.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_nn_start    <= 1'b0;
      r_nn_pixel    <= '0;
      r_nn_label    <= '0;
      r_done_count  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_nn_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state    <= S_LAUNCH;
            r_nn_start <= 1'b1;
            r_nn_pixel <= w_head[NPIXEL-1:0];
            r_nn_label <= w_head[EW-1:NPIXEL];
          end
        end
        S_LAUNCH: begin
          r_timer <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (bus.nn_done) begin
            r_state <= S_IDLE;
            if (r_done_count != '1) begin
              r_done_count <= r_done_count + 1'b1;
            end
          end else if (w_timer_exp) begin
            r_state       <= S_IDLE;
            r_timeout_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of samples rejected for a full FIFO or an illegal label.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign bus.nn_start    = r_nn_start;
  assign bus.nn_pixel    = r_nn_pixel;
  assign bus.nn_label    = r_nn_label;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.fifo_level  = r_level;
  assign bus.done_count  = r_done_count;
  assign bus.drop_count  = r_drop_count;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_nn_train_scheduler.sv
// Directed bench for nn_train_scheduler. Inputs change and outputs are
// sampled on the falling clock edge; expected values are hand-derived.
module tb_nn_train_scheduler;

  localparam int NPIXEL   = 16;
  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int TIMEOUT  = 16;
  localparam int CNT_BITS = 14;

  logic clk = 1'b0;
  logic reset_b;
  int   assertCount = 0;
  int   failCount   = 0;
  logic sawStart;
  logic [3:0] expLabels [4];

  nn_train_scheduler_if #(.NPIXEL(NPIXEL), .AW(AW), .CNT_BITS(CNT_BITS)) bus ();

  nn_train_scheduler #(
    .NPIXEL(NPIXEL), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .bus(bus.slave)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected normal completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Single comparison point for every check
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one sample for exactly one rising edge
  task automatic applyStimulus(input logic [3:0] label, input logic [NPIXEL-1:0] pixel);
    bus.sample_valid = 1'b1;
    bus.sample_label = label;
    bus.sample_pixel = pixel;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulseDone();
    bus.nn_done = 1'b1;
    @(negedge clk);
    bus.nn_done = 1'b0;
  endtask

  function automatic logic [NPIXEL-1:0] pix(input logic [3:0] l);
    return {4{l}};
  endfunction

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_pixel = '0;
    bus.sample_label = '0;
    bus.hold         = 1'b0;
    bus.nn_done      = 1'b0;
    reset_b          = 1'b0;
    expLabels[0] = 4'd2; expLabels[1] = 4'd3; expLabels[2] = 4'd4; expLabels[3] = 4'd5;

    // Reset state
    cycles(3);
    checkOutput("rst_start", 32'(bus.nn_start), 0);
    checkOutput("rst_busy",  32'(bus.busy), 0);
    checkOutput("rst_level", 32'(bus.fifo_level), 0);
    checkOutput("rst_done",  32'(bus.done_count), 0);
    checkOutput("rst_drop",  32'(bus.drop_count), 0);
    checkOutput("rst_terr",  32'(bus.timeout_err), 0);
    checkOutput("rst_label", 32'(bus.nn_label), 0);
    reset_b = 1'b1;
    cycles(1);

    // Single sample: start pulse two edges after the sample
    applyStimulus(4'd7, 16'hA5A5);
    checkOutput("s1_level", 32'(bus.fifo_level), 1);
    checkOutput("s1_start_early", 32'(bus.nn_start), 0);
    cycles(1);
    checkOutput("s1_start", 32'(bus.nn_start), 1);
    checkOutput("s1_label", 32'(bus.nn_label), 7);
    checkOutput("s1_pixel", 32'(bus.nn_pixel), 32'h0000A5A5);
    checkOutput("s1_busy",  32'(bus.busy), 1);
    checkOutput("s1_level_pop", 32'(bus.fifo_level), 0);
    cycles(1);
    checkOutput("s1_start_once", 32'(bus.nn_start), 0);
    cycles(8);
    checkOutput("s1_busy_run", 32'(bus.busy), 1);
    pulseDone();
    checkOutput("s1_done", 32'(bus.done_count), 1);
    checkOutput("s1_idle", 32'(bus.busy), 0);
    checkOutput("s1_label_hold", 32'(bus.nn_label), 7);
    checkOutput("s1_pixel_hold", 32'(bus.nn_pixel), 32'h0000A5A5);
    checkOutput("s1_terr", 32'(bus.timeout_err), 0);

    // Burst: first sample launches, then six more arrive while busy
    applyStimulus(4'd1, pix(4'd1));
    applyStimulus(4'd2, pix(4'd2));
    checkOutput("b_pushpop_level", 32'(bus.fifo_level), 1);
    checkOutput("b_start", 32'(bus.nn_start), 1);
    checkOutput("b_label", 32'(bus.nn_label), 1);
    applyStimulus(4'd3, pix(4'd3));
    applyStimulus(4'd4, pix(4'd4));
    applyStimulus(4'd5, pix(4'd5));
    checkOutput("b_full", 32'(bus.fifo_level), 4);
    checkOutput("b_drop0", 32'(bus.drop_count), 0);
    applyStimulus(4'd6, pix(4'd6));
    applyStimulus(4'd8, pix(4'd8));
    checkOutput("b_level_cap", 32'(bus.fifo_level), 4);
    checkOutput("b_drop2", 32'(bus.drop_count), 2);
    pulseDone();
    checkOutput("b_done_first", 32'(bus.done_count), 2);
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      checkOutput($sformatf("b_start_%0d", i), 32'(bus.nn_start), 1);
      checkOutput($sformatf("b_label_%0d", i), 32'(bus.nn_label), 32'(expLabels[i]));
      checkOutput($sformatf("b_pixel_%0d", i), 32'(bus.nn_pixel), 32'(pix(expLabels[i])));
      checkOutput($sformatf("b_level_%0d", i), 32'(bus.fifo_level), 32'(3 - i));
      cycles(1);
      pulseDone();
      checkOutput($sformatf("b_done_%0d", i), 32'(bus.done_count), 32'(3 + i));
    end
    checkOutput("b_idle_end", 32'(bus.busy), 0);

    // Watchdog: no done for a full window of RUN cycles
    applyStimulus(4'd9, pix(4'd9));
    cycles(1);
    checkOutput("t_start", 32'(bus.nn_start), 1);
    checkOutput("t_label9", 32'(bus.nn_label), 9);
    cycles(1);
    applyStimulus(4'd0, 16'h0F0F);
    checkOutput("t_queued", 32'(bus.fifo_level), 1);
    cycles(14);
    checkOutput("t_busy_last", 32'(bus.busy), 1);
    checkOutput("t_terr_before", 32'(bus.timeout_err), 0);
    cycles(1);
    checkOutput("t_idle", 32'(bus.busy), 0);
    checkOutput("t_terr", 32'(bus.timeout_err), 1);
    checkOutput("t_done_same", 32'(bus.done_count), 6);
    cycles(1);
    checkOutput("t_relaunch", 32'(bus.nn_start), 1);
    checkOutput("t_relabel", 32'(bus.nn_label), 0);
    checkOutput("t_repixel", 32'(bus.nn_pixel), 32'h00000F0F);
    cycles(1);
    pulseDone();
    checkOutput("t_done", 32'(bus.done_count), 7);
    checkOutput("t_terr_sticky", 32'(bus.timeout_err), 1);

    // Hold gates launches; illegal label is dropped
    bus.hold = 1'b1;
    applyStimulus(4'd3, pix(4'd3));
    applyStimulus(4'd4, pix(4'd4));
    applyStimulus(4'd12, pix(4'd12));
    checkOutput("h_drop_label", 32'(bus.drop_count), 3);
    checkOutput("h_level", 32'(bus.fifo_level), 2);
    sawStart = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (bus.nn_start || bus.busy) sawStart = 1'b1;
    end
    checkOutput("h_no_start", 32'(sawStart), 0);
    bus.hold = 1'b0;
    cycles(1);
    checkOutput("h_start", 32'(bus.nn_start), 1);
    checkOutput("h_label", 32'(bus.nn_label), 3);
    checkOutput("h_level_pop", 32'(bus.fifo_level), 1);
    cycles(1);
    bus.hold = 1'b1;
    cycles(3);
    checkOutput("h_no_abort", 32'(bus.busy), 1);
    pulseDone();
    checkOutput("h_done", 32'(bus.done_count), 8);
    cycles(5);
    checkOutput("h_held_start", 32'(bus.nn_start), 0);
    checkOutput("h_held_busy", 32'(bus.busy), 0);
    checkOutput("h_held_level", 32'(bus.fifo_level), 1);

    // Push and pop in the same cycle at level 1
    bus.hold = 1'b0;
    applyStimulus(4'd5, pix(4'd5));
    checkOutput("e_pp_level", 32'(bus.fifo_level), 1);
    checkOutput("e_pp_start", 32'(bus.nn_start), 1);
    checkOutput("e_pp_label", 32'(bus.nn_label), 4);

    // Done pulse during LAUNCH must not end the pass
    pulseDone();
    checkOutput("e_launch_done_busy", 32'(bus.busy), 1);
    checkOutput("e_launch_done_cnt", 32'(bus.done_count), 8);

    // Push while full with a simultaneous pop is still dropped
    applyStimulus(4'd6, pix(4'd6));
    applyStimulus(4'd7, pix(4'd7));
    applyStimulus(4'd8, pix(4'd8));
    checkOutput("e_full", 32'(bus.fifo_level), 4);
    pulseDone();
    checkOutput("e_done9", 32'(bus.done_count), 9);
    applyStimulus(4'd9, pix(4'd9));
    checkOutput("e_fullpop_level", 32'(bus.fifo_level), 3);
    checkOutput("e_fullpop_drop", 32'(bus.drop_count), 4);
    checkOutput("e_fullpop_label", 32'(bus.nn_label), 5);

    // Asynchronous reset in the middle of a pass
    cycles(3);
    reset_b = 1'b0;
    #1;
    checkOutput("r_start", 32'(bus.nn_start), 0);
    checkOutput("r_busy", 32'(bus.busy), 0);
    checkOutput("r_level", 32'(bus.fifo_level), 0);
    checkOutput("r_done", 32'(bus.done_count), 0);
    checkOutput("r_terr", 32'(bus.timeout_err), 0);
    @(negedge clk);
    reset_b = 1'b1;
    cycles(2);
    checkOutput("r_stay_idle", 32'(bus.busy), 0);
    checkOutput("r_no_start", 32'(bus.nn_start), 0);

    // Done pulse in IDLE is ignored
    pulseDone();
    checkOutput("i_done_ignored", 32'(bus.done_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
